systolic_tile_sched: RTL and testbench

- Tile-level scheduler above the systolic array; the array itself is an L x L PE grid with A/B/C buffers.
- Walks an M x N x K tile loop. For each output tile it issues C, A and B buffer fills through one shared load/store request port, then runs the systolic phase per K step.
- After the last K step it runs the accumulate phase and issues the write-back.
- Owns all phase counters, so the array only sees its enables.

---
 rtl/systolic_tile_sched_pkg.sv | 32 +++
 rtl/tsched_idx_walker.sv | 54 +++++
 rtl/systolic_tile_sched.sv | 181 ++++++++++++++++++
 tb/tb_systolic_tile_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_tile_sched_pkg.sv
// Shared types for the systolic tile scheduler: phase encoding, buffer
// selects and the load/store request bundle.
package systolic_tile_sched_pkg;

  // Index field width carried in the request bundle.
  localparam int TS_CNT_W = 16;

  localparam logic [2:0] SEL_C = 3'b001;
  localparam logic [2:0] SEL_A = 3'b010;
  localparam logic [2:0] SEL_B = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD_C = 3'd1,
    ST_LD_A = 3'd2,
    ST_LD_B = 3'd3,
    ST_SYS  = 3'd4,
    ST_ACC  = 3'd5,
    ST_WB   = 3'd6,
    ST_DONE = 3'd7
  } tsched_state_t;

  typedef struct packed {
    logic                valid;
    logic [2:0]          sel;
    logic                write;
    logic [TS_CNT_W-1:0] m;
    logic [TS_CNT_W-1:0] n;
    logic [TS_CNT_W-1:0] k;
  } tsched_req_t;

endpackage

// File: rtl/tsched_idx_walker.sv
// Nested m/n/k tile index counters. k steps inside a tile; an m/n step
// also rewinds k so the next tile starts its K loop from 0.
module tsched_idx_walker import systolic_tile_sched_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             step_k,
  input  logic             step_mn,
  input  logic [CNT_W-1:0] cnt_m,
  input  logic [CNT_W-1:0] cnt_n,
  input  logic [CNT_W-1:0] cnt_k,
  output logic [CNT_W-1:0] m,
  output logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] k,
  output logic             last_k,
  output logic             last_mn
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic last_m, last_n;

  // Counts are nonzero whenever the walker runs, so count-1 never underflows.
  assign last_k  = (k == cnt_k - ONE);
  assign last_n  = (n == cnt_n - ONE);
  assign last_m  = (m == cnt_m - ONE);
  assign last_mn = last_m && last_n;

  // n is the inner tile loop, m the outer; both wrap to 0 at their count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m <= '0;
      n <= '0;
      k <= '0;
    end else if (clear) begin
      m <= '0;
      n <= '0;
      k <= '0;
    end else if (step_mn) begin
      k <= '0;
      if (last_n) begin
        n <= '0;
        m <= last_m ? '0 : m + ONE;
      end else begin
        n <= n + ONE;
      end
    end else if (step_k) begin
      k <= k + ONE;
    end
  end

endmodule

// File: rtl/systolic_tile_sched.sv
// Tile-level scheduler: walks the M x N x K tile loop, issues C/A/B fills and
// the C write-back over one request port, and times the systolic and
// accumulate phases so the array only sees sys_en / acc_en.
module systolic_tile_sched import systolic_tile_sched_pkg::*; #(
  parameter int CNT_W  = TS_CNT_W,
  parameter int TIME_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_m_tiles,
  input  logic [CNT_W-1:0]  cfg_n_tiles,
  input  logic [CNT_W-1:0]  cfg_k_tiles,
  input  logic [TIME_W-1:0] cfg_sys_time,
  input  logic [TIME_W-1:0] cfg_acc_time,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [2:0]        req_sel,
  output logic              req_write,
  output logic [CNT_W-1:0]  req_m,
  output logic [CNT_W-1:0]  req_n,
  output logic [CNT_W-1:0]  req_k,
  input  logic              xfer_finish,
  output logic              sys_en,
  output logic              acc_en,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [TIME_W-1:0] T_ONE = {{(TIME_W-1){1'b0}}, 1'b1};

  tsched_state_t     state_q, state_d;
  logic              wait_q, wait_d;     // 0: request pending, 1: awaiting finish
  logic [TIME_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0]  m_cnt, n_cnt, k_cnt;
  logic [TIME_W-1:0] sys_t, acc_t;
  logic [CNT_W-1:0]  idx_m, idx_n, idx_k;
  logic              last_k, last_mn;
  logic              xfer_st, req_vld, fin, zero_cfg;
  logic              clear, step_k, step_mn;
  tsched_req_t       req;

  assign xfer_st  = (state_q == ST_LD_C) || (state_q == ST_LD_A) ||
                    (state_q == ST_LD_B) || (state_q == ST_WB);
  assign req_vld  = xfer_st && !wait_q;
  // A finish only counts once the transfer has been accepted.
  assign fin      = xfer_st && wait_q && xfer_finish;
  assign zero_cfg = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_k_tiles == '0);
  assign clear    = (state_q == ST_IDLE) && start;
  assign step_k   = !abort && (state_q == ST_SYS) && (ph_q == '0) && !last_k;
  assign step_mn  = !abort && (state_q == ST_WB) && fin && !last_mn;

  tsched_idx_walker #(.CNT_W(CNT_W)) u_walk (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .step_k  (step_k),
    .step_mn (step_mn),
    .cnt_m   (m_cnt),
    .cnt_n   (n_cnt),
    .cnt_k   (k_cnt),
    .m       (idx_m),
    .n       (idx_n),
    .k       (idx_k),
    .last_k  (last_k),
    .last_mn (last_mn)
  );

  // Next phase, sub-phase and countdown; abort overrides everything.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ph_d    = ph_q;
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      wait_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d = zero_cfg ? ST_DONE : ST_LD_C;
          wait_d  = 1'b0;
        end
        ST_LD_C, ST_LD_A, ST_LD_B, ST_WB: begin
          if (!wait_q) begin
            if (req_ready) wait_d = 1'b1;
          end else if (xfer_finish) begin
            wait_d = 1'b0;
            case (state_q)
              ST_LD_C: state_d = ST_LD_A;
              ST_LD_A: state_d = ST_LD_B;
              ST_LD_B: begin
                state_d = ST_SYS;
                ph_d    = sys_t;
              end
              default: state_d = last_mn ? ST_DONE : ST_LD_C;
            endcase
          end
        end
        ST_SYS: begin
          if (ph_q == '0) begin
            if (last_k) begin
              state_d = ST_ACC;
              ph_d    = acc_t;
            end else begin
              state_d = ST_LD_A;
            end
          end else begin
            ph_d = ph_q - T_ONE;
          end
        end
        ST_ACC: begin
          if (ph_q == '0) state_d = ST_WB;
          else            ph_d    = ph_q - T_ONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, countdown, phase enables and job configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b0;
      ph_q    <= '0;
      sys_en  <= 1'b0;
      acc_en  <= 1'b0;
      cfg_err <= 1'b0;
      m_cnt   <= '0;
      n_cnt   <= '0;
      k_cnt   <= '0;
      sys_t   <= '0;
      acc_t   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ph_q    <= ph_d;
      sys_en  <= (state_d == ST_SYS);
      acc_en  <= (state_d == ST_ACC);
      if (clear) begin
        cfg_err <= zero_cfg;
        m_cnt   <= cfg_m_tiles;
        n_cnt   <= cfg_n_tiles;
        k_cnt   <= cfg_k_tiles;
        sys_t   <= cfg_sys_time;
        acc_t   <= cfg_acc_time;
      end
    end
  end

  // Request bundle; fields read zero whenever no request is pending.
  always_comb begin
    req = '0;
    if (req_vld) begin
      req.valid = 1'b1;
      req.write = (state_q == ST_WB);
      req.m     = TS_CNT_W'(idx_m);
      req.n     = TS_CNT_W'(idx_n);
      case (state_q)
        ST_LD_A: req.sel = SEL_A;
        ST_LD_B: req.sel = SEL_B;
        default: req.sel = SEL_C;
      endcase
      // C fill and write-back are not tied to a K step.
      if (state_q == ST_LD_A || state_q == ST_LD_B) req.k = TS_CNT_W'(idx_k);
    end
  end

  assign req_valid = req.valid;
  assign req_sel   = req.sel;
  assign req_write = req.write;
  assign req_m     = req.m[CNT_W-1:0];
  assign req_n     = req.n[CNT_W-1:0];
  assign req_k     = req.k[CNT_W-1:0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Bench for systolic_tile_sched: a memory responder with optional random
// backpressure, a negedge monitor, and a tile-loop reference that lists the
// expected requests and phase-cycle totals for each job.
module tb_systolic_tile_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cfg_m_tiles = '0, cfg_n_tiles = '0, cfg_k_tiles = '0;
  logic [15:0] cfg_sys_time = '0, cfg_acc_time = '0;
  logic        req_valid, req_write, sys_en, acc_en, busy, done, cfg_err;
  logic        req_ready = 1'b1;
  logic        xfer_finish = 1'b0;
  logic [2:0]  req_sel;
  logic [15:0] req_m, req_n, req_k;

  systolic_tile_sched dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
    .cfg_sys_time(cfg_sys_time), .cfg_acc_time(cfg_acc_time),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_write(req_write), .req_m(req_m), .req_n(req_n), .req_k(req_k),
    .xfer_finish(xfer_finish), .sys_en(sys_en), .acc_en(acc_en),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [58:0] outs;
  assign outs = {req_valid, req_sel, req_write, req_m, req_n, req_k,
                 sys_en, acc_en, busy, done, cfg_err};

  int n_assert = 0;
  int n_fail   = 0;

  // responder / monitor shared state
  int  pend = 0, hold = 0, fin_dly = 2;
  bit  rnd_rdy = 0, hold_arm = 0, spur_en = 0;
  bit  acc_q = 0, flush_q = 0, out_flag = 0, prev_wait = 0, prev_abort = 0;
  logic [51:0] prev_fields = '0;
  int  sys_cnt, acc_cnt, done_cnt, valid_cnt, overlap, order_err, stab_err;
  logic [51:0] obs_q[$];
  logic [51:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory side: ready (optionally random or held low) and a finish pulse
  // fin_dly cycles after each accept.
  always begin
    @(posedge clk); #1;
    xfer_finish = 1'b0;
    if (flush_q) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) xfer_finish = 1'b1;
      end
      if (acc_q) pend = fin_dly;
    end
    if (hold_arm && req_valid && req_sel == 3'b010) begin
      hold = 5;
      hold_arm = 0;
    end
    if (hold > 0) begin
      hold--;
      req_ready = 1'b0;
      if (spur_en && req_valid) xfer_finish = 1'b1;
    end else begin
      req_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: records accepted requests, counts phase cycles, and flags
  // unstable pending requests or a new request before the last one finished.
  always @(negedge clk) begin
    logic [51:0] cur;
    cur = {req_sel, req_write, req_m, req_n, req_k};
    flush_q = abort || !rst;
    if (rst) begin
      if (prev_wait && !prev_abort && (!req_valid || cur != prev_fields)) stab_err++;
      if (req_valid && out_flag) order_err++;
      if (req_valid) valid_cnt++;
      if (sys_en) sys_cnt++;
      if (acc_en) acc_cnt++;
      if (done) done_cnt++;
      if (sys_en && acc_en) overlap++;
    end
    acc_q = req_valid && req_ready && rst && !abort;
    if (acc_q) begin
      obs_q.push_back(cur);
      out_flag = 1;
    end else if (xfer_finish) begin
      out_flag = 0;
    end
    if (flush_q) out_flag = 0;
    prev_wait   = req_valid && !req_ready && rst;
    prev_abort  = abort;
    prev_fields = cur;
  end

  task automatic clr_stats();
    sys_cnt = 0; acc_cnt = 0; done_cnt = 0; valid_cnt = 0;
    overlap = 0; order_err = 0; stab_err = 0;
    obs_q.delete();
  endtask

  task automatic set_cfg(input int m, input int n, input int k, input int st, input int at);
    cfg_m_tiles = 16'(m); cfg_n_tiles = 16'(n); cfg_k_tiles = 16'(k);
    cfg_sys_time = 16'(st); cfg_acc_time = 16'(at);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Full job: reference request list from the M/N/K loop nest, then
  // compare order, contents and phase-cycle totals.
  task automatic run_job(input int m, input int n, input int k, input int st,
                         input int at, input bit rnd, input int dly);
    bit got;
    set_cfg(m, n, k, st, at);
    rnd_rdy = rnd;
    fin_dly = dly;
    exp_q.delete();
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++) begin
        exp_q.push_back({3'b001, 1'b0, 16'(mi), 16'(ni), 16'd0});
        for (int ki = 0; ki < k; ki++) begin
          exp_q.push_back({3'b010, 1'b0, 16'(mi), 16'(ni), 16'(ki)});
          exp_q.push_back({3'b100, 1'b0, 16'(mi), 16'(ni), 16'(ki)});
        end
        exp_q.push_back({3'b001, 1'b1, 16'(mi), 16'(ni), 16'd0});
      end
    clr_stats();
    pulse_start();
    chk("cfg_err_clear", cfg_err, 0);
    // later config changes must not affect the running job
    cfg_m_tiles = 16'($urandom); cfg_n_tiles = 16'($urandom); cfg_k_tiles = 16'($urandom);
    cfg_sys_time = 16'($urandom); cfg_acc_time = 16'($urandom);
    got = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", got, 1);
    @(negedge clk);
    chk("idle_after_done", {busy, done}, 0);
    @(posedge clk); #1;
    chk("req_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("req[%0d]", i), obs_q[i], exp_q[i]);
    chk("sys_cycles", sys_cnt, m * n * k * (st + 1));
    chk("acc_cycles", acc_cnt, m * n * (at + 1));
    chk("done_pulses", done_cnt, 1);
    chk("sys_acc_overlap", overlap, 0);
    chk("req_before_finish", order_err, 0);
    chk("req_unstable", stab_err, 0);
  endtask

  initial begin
    bit got;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", outs, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // single tile
    run_job(1, 1, 1, 3, 1, 0, 2);
    // K loop
    run_job(1, 1, 3, 2, 1, 0, 1);
    // tile walk
    run_job(2, 2, 1, 1, 0, 0, 2);
    // backpressure during LD_A with early finish pulses
    hold_arm = 1; spur_en = 1;
    run_job(1, 1, 1, 2, 1, 0, 2);
    hold_arm = 0; spur_en = 0;

    // zero config
    set_cfg(2, 3, 0, 1, 1);
    clr_stats();
    pulse_start();
    chk("zero_cfg_err", cfg_err, 1);
    chk("zero_done", done, 1);
    @(posedge clk); #1;
    chk("zero_idle", busy, 0);
    repeat (3) @(posedge clk); #1;
    chk("zero_no_req", valid_cnt, 0);
    chk("zero_done_pulses", done_cnt, 1);
    chk("zero_cfg_err_sticky", cfg_err, 1);
    run_job(1, 2, 1, 0, 0, 0, 1);

    // abort mid-SYS
    set_cfg(1, 1, 2, 10, 2);
    rnd_rdy = 0; fin_dly = 1;
    clr_stats();
    pulse_start();
    got = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (sys_en) begin got = 1; break; end
    end
    chk("abort_reach_sys", got, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", {busy, sys_en, acc_en, req_valid}, 0);
    repeat (5) @(posedge clk); #1;
    chk("abort_no_done", done_cnt, 0);
    run_job(1, 1, 2, 1, 1, 0, 2);

    // asynchronous reset mid-WB
    set_cfg(1, 1, 1, 2, 2);
    rnd_rdy = 0; fin_dly = 3;
    clr_stats();
    pulse_start();
    got = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (req_valid && req_write) begin got = 1; break; end
    end
    chk("rst_reach_wb", got, 1);
    #2 rst = 1'b0;
    #1 chk("rst_async_zero", outs, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_job(2, 1, 2, 1, 2, 0, 1);

    // random jobs with random backpressure
    for (int j = 0; j < 5; j++)
      run_job($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3),
              $urandom_range(0, 4), $urandom_range(0, 4), 1, $urandom_range(1, 3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
